mb_crc_serial_link: RTL and testbench
=====================================

Name: mb_crc_serial_link

Overview:
Parametrised serial CRC link combining transmitter and checker in one block. It generalises the fixed 8-bit / CRC-3 serial link in data width, CRC width and polynomial, and adds two things the old link lacked: programmable single-bit error injection on transmit and a framed receive path with a held error flag. TX serialises Data_in MSB-first and appends the CRC. RX deserialises a frame, recomputes the CRC and flags any non-zero remainder.

Parameters:
DATA_W, 8, payload bits per frame (>=2)
CRC_W, 3, CRC register width (>=2)
POLY, 3'b011, generator polynomial without implicit x^CRC_W term (default x^3+x+1)
CRC_INIT, 0, CRC register value at frame start (TX and RX)

Ports:
CLK  in  1  rising-edge clock
CLEAR_bar  in  1  asynchronous active-low reset
Enable  in  1  TX bit-step enable; TX state frozen when low
Start  in  1  request frame transmission (sampled in IDLE with Enable=1)
Data_in  in  DATA_W  payload, latched on accepted Start
Err_Inject  in  1  latched on accepted Start; enables error injection for the frame
Err_Pos  in  $clog2(DATA_W+CRC_W)  frame bit index (0 = first bit on line) to invert; latched on Start
Busy  out  1  TX frame in progress
Tx_Out  out  1  serial line bit
Tx_Valid  out  1  Tx_Out carries a frame bit this cycle
Rx_In  in  1  received serial bit
Rx_Valid  in  1  Rx_In valid strobe
Rx_Abort  in  1  synchronous RX frame discard
Rx_Data  out  DATA_W  last received payload
Rx_Done  out  1  one-cycle pulse: frame complete
Error  out  1  CRC fail of last frame, held until next Rx_Done

Behaviour:
- Reset (CLEAR_bar=0, async): TX state IDLE, all counters/shift/CRC regs = 0 (CRC regs = CRC_INIT); Busy=0, Tx_Out=0, Tx_Valid=0, Rx_Data=0, Rx_Done=0, Error=0. Reset mid-frame aborts both paths; no partial Rx_Done.
- CRC step, shared by TX and RX, for input bit b: fb = crc[CRC_W-1]^b; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
- TX FSM states IDLE, DATA, CRC. Tx_Out, Tx_Valid and Busy decode from registers only (glitch-free).
- IDLE: Tx_Valid=0, Tx_Out=0. If Enable & Start: load shreg=Data_in, crc=CRC_INIT, bitcnt=0, latch inject controls, go DATA. Start in DATA/CRC is ignored.
- DATA: Tx_Out = shreg[MSB] ^ (inj & bitcnt==Err_Pos_l). Each Enable cycle: CRC step on the un-inverted bit, shift left, bitcnt++. After DATA_W bits go CRC.
- CRC: Tx_Out = crc[CRC_W-1] ^ injection term. Each Enable cycle: shift crc left, bitcnt++. After CRC_W bits go IDLE.
- Bit timing: a frame occupies exactly DATA_W+CRC_W Enable-high cycles. Back-to-back frames have at least one IDLE cycle. Err_Pos >= DATA_W+CRC_W means no inversion.
- RX: rcnt counts Rx_Valid cycles. Bits 0..DATA_W-1 shift into rshreg (MSB first) and the CRC. Bits DATA_W..DATA_W+CRC_W-1 go into the CRC only.
- RX frame end: on the cycle the last bit is accepted, the next edge sets Rx_Done=1 for one cycle, Rx_Data=rshreg, and Error=(updated rcrc != 0). rcnt=0 and rcrc=CRC_INIT for the next frame.
- Rx_Abort: rcnt=0, rcrc=CRC_INIT; Rx_Data and Error are unchanged. Rx_Abort has priority over a simultaneous Rx_Valid, whose bit is dropped.
- TX and RX are independent; loopback is Tx_Out->Rx_In with Tx_Valid->Rx_Valid (Enable and Rx_Valid both high per bit).

Test Plan:
- Reset mid-frame: assert CLEAR_bar=0 during DATA -> all outputs 0 immediately; after release Busy=0 and no Rx_Done.
- Loopback, Data_in=8'hA5, Enable=1 continuous, no injection -> line bits 1010_0101_101 over 11 cycles, Busy high 11 cycles; then Rx_Done pulse, Rx_Data=8'hA5, Error=0.
- Same frame with Err_Inject=1, Err_Pos=0 -> line starts 0; Rx_Done with Rx_Data=8'h25, Error=1. Repeat with Err_Pos=9 -> Rx_Data=8'hA5, Error=1.
- Enable toggled 1/0 every cycle with Data_in=8'h00 -> line 00000000_000 across 22 cycles, Tx_Out stable while Enable=0; Start pulsed mid-frame is ignored.
- RX: 5 bits, then Rx_Abort together with Rx_Valid, then a clean 8'hA5 frame -> single Rx_Done, Rx_Data=8'hA5, Error=0; previous Error value held until that pulse.
- Parameter sweep DATA_W=16, CRC_W=8, POLY=8'h07: 64 random loopback frames -> Error=0 on all; every single-bit injection position gives Error=1.

Source files
------------

// File: rtl/mb_crc_serial_link.sv
// Serial CRC link: a framed transmitter with optional single-bit error injection,
// and an independent receiver that recomputes the CRC and holds the result.
`timescale 1ns/1ps

module mb_crc_serial_link #(
  parameter int                DATA_W   = 8,
  parameter int                CRC_W    = 3,
  parameter logic [CRC_W-1:0]  POLY     = 3'b011,
  parameter logic [CRC_W-1:0]  CRC_INIT = '0
) (
  input  logic                                  CLK,
  input  logic                                  CLEAR_bar,
  input  logic                                  Enable,
  input  logic                                  Start,
  input  logic [DATA_W-1:0]                     Data_in,
  input  logic                                  Err_Inject,
  input  logic [$clog2(DATA_W+CRC_W)-1:0]       Err_Pos,
  output logic                                  Busy,
  output logic                                  Tx_Out,
  output logic                                  Tx_Valid,
  input  logic                                  Rx_In,
  input  logic                                  Rx_Valid,
  input  logic                                  Rx_Abort,
  output logic [DATA_W-1:0]                     Rx_Data,
  output logic                                  Rx_Done,
  output logic                                  Error
);

  // state  | meaning
  // S_IDLE | no frame; waits for Enable & Start
  // S_DATA | payload bits on the line, MSB first, CRC accumulating
  // S_CRC  | CRC register shifted out MSB first
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} tx_state_t;

  localparam int FRAME_W = DATA_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  tx_state_t          r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_shreg, w_shreg_nxt;
  logic [CRC_W-1:0]   r_crc, w_crc_nxt;
  logic [CNT_W-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic               r_inj, w_inj_nxt;
  logic [CNT_W-1:0]   r_err_pos, w_err_pos_nxt;
  logic               w_inj_hit;

  always_ff @(posedge CLK or negedge CLEAR_bar) begin
    if (!CLEAR_bar) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_crc     <= CRC_INIT;
      r_bitcnt  <= '0;
      r_inj     <= 1'b0;
      r_err_pos <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_crc     <= w_crc_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_inj     <= w_inj_nxt;
      r_err_pos <= w_err_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_crc_nxt     = r_crc;
    w_bitcnt_nxt  = r_bitcnt;
    w_inj_nxt     = r_inj;
    w_err_pos_nxt = r_err_pos;
    case (r_state)
      S_IDLE: begin
        if (Enable && Start) begin
          w_state_nxt   = S_DATA;
          w_shreg_nxt   = Data_in;
          w_crc_nxt     = CRC_INIT;
          w_bitcnt_nxt  = '0;
          w_inj_nxt     = Err_Inject;
          w_err_pos_nxt = Err_Pos;
        end
      end
      S_DATA: begin
        if (Enable) begin
          // CRC always sees the true payload bit; injection only corrupts the line
          w_crc_nxt    = crc_step(r_crc, r_shreg[DATA_W-1]);
          w_shreg_nxt  = {r_shreg[DATA_W-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          if (r_bitcnt == LAST_DATA) w_state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        if (Enable) begin
          w_crc_nxt    = {r_crc[CRC_W-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          if (r_bitcnt == LAST_BIT) begin
            w_state_nxt  = S_IDLE;
            w_bitcnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An out-of-range Err_Pos never equals bitcnt, so it disables inversion
  assign w_inj_hit = r_inj & (r_bitcnt == r_err_pos);

  always_comb begin
    Tx_Out = 1'b0;
    case (r_state)
      S_DATA:  Tx_Out = r_shreg[DATA_W-1] ^ w_inj_hit;
      S_CRC:   Tx_Out = r_crc[CRC_W-1] ^ w_inj_hit;
      default: Tx_Out = 1'b0;
    endcase
  end

  assign Busy     = (r_state != S_IDLE);
  assign Tx_Valid = (r_state != S_IDLE);

  logic [CNT_W-1:0]  r_rcnt;
  logic [DATA_W-1:0] r_rshreg;
  logic [CRC_W-1:0]  r_rcrc;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_done;
  logic              r_error;
  logic [CRC_W-1:0]  w_rcrc_step;
  logic              w_rx_last;

  assign w_rcrc_step = crc_step(r_rcrc, Rx_In);
  assign w_rx_last   = (r_rcnt == LAST_BIT);

  always_ff @(posedge CLK or negedge CLEAR_bar) begin
    if (!CLEAR_bar) begin
      r_rcnt    <= '0;
      r_rshreg  <= '0;
      r_rcrc    <= CRC_INIT;
      r_rx_data <= '0;
      r_rx_done <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      if (Rx_Abort) begin
        r_rcnt <= '0;
        r_rcrc <= CRC_INIT;
      end else if (Rx_Valid) begin
        if (r_rcnt <= LAST_DATA) r_rshreg <= {r_rshreg[DATA_W-2:0], Rx_In};
        // The last bit is always a CRC bit, so rshreg is already complete here
        if (w_rx_last) begin
          r_rx_done <= 1'b1;
          r_rx_data <= r_rshreg;
          r_error   <= |w_rcrc_step;
          r_rcnt    <= '0;
          r_rcrc    <= CRC_INIT;
        end else begin
          r_rcnt <= r_rcnt + CNT_W'(1);
          r_rcrc <= w_rcrc_step;
        end
      end
    end
  end

  assign Rx_Data = r_rx_data;
  assign Rx_Done = r_rx_done;
  assign Error   = r_error;

endmodule

// File: tb/tb_mb_crc_serial_link.sv
// Bench for mb_crc_serial_link: default 8/3 instance plus a 16/8 (poly 0x07) instance,
// checked against a polynomial long-division reference model.
`timescale 1ns/1ps

module tb_mb_crc_serial_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // default instance
  logic       en_a, start_a, inj_a, abort_a, lb_a, rxin_m, rxv_m;
  logic [7:0] din_a;
  logic [3:0] pos_a;
  logic       busy_a, txo_a, txv_a, rx_done_a, err_a, rxin_a, rxv_a;
  logic [7:0] rxdata_a;

  assign rxin_a = lb_a ? txo_a : rxin_m;
  assign rxv_a  = lb_a ? (txv_a & en_a) : rxv_m;

  mb_crc_serial_link u_dut_a (
    .CLK(clk), .CLEAR_bar(rst_n), .Enable(en_a), .Start(start_a),
    .Data_in(din_a), .Err_Inject(inj_a), .Err_Pos(pos_a),
    .Busy(busy_a), .Tx_Out(txo_a), .Tx_Valid(txv_a),
    .Rx_In(rxin_a), .Rx_Valid(rxv_a), .Rx_Abort(abort_a),
    .Rx_Data(rxdata_a), .Rx_Done(rx_done_a), .Error(err_a)
  );

  // wide instance, always in loopback
  logic        en_b, start_b, inj_b, abort_b;
  logic [15:0] din_b;
  logic [4:0]  pos_b;
  logic        busy_b, txo_b, txv_b, rx_done_b, err_b, rxv_b;
  logic [15:0] rxdata_b;

  assign rxv_b = txv_b & en_b;

  mb_crc_serial_link #(.DATA_W(16), .CRC_W(8), .POLY(8'h07)) u_dut_b (
    .CLK(clk), .CLEAR_bar(rst_n), .Enable(en_b), .Start(start_b),
    .Data_in(din_b), .Err_Inject(inj_b), .Err_Pos(pos_b),
    .Busy(busy_b), .Tx_Out(txo_b), .Tx_Valid(txv_b),
    .Rx_In(txo_b), .Rx_Valid(rxv_b), .Rx_Abort(abort_b),
    .Rx_Data(rxdata_b), .Rx_Done(rx_done_b), .Error(err_b)
  );

  logic        sel;
  logic        t_busy, t_txo, t_txv, t_rx_done, t_err;
  logic [31:0] t_rx_data;
  assign t_busy    = sel ? busy_b    : busy_a;
  assign t_txo     = sel ? txo_b     : txo_a;
  assign t_txv     = sel ? txv_b     : txv_a;
  assign t_rx_done = sel ? rx_done_b : rx_done_a;
  assign t_err     = sel ? err_b     : err_a;
  assign t_rx_data = sel ? {16'b0, rxdata_b} : {24'b0, rxdata_a};

  logic       last_err_a;
  logic [7:0] last_data_a;

  // Remainder of an nb-bit polynomial m modulo x^k + poly
  function automatic logic [31:0] rem_of(input logic [63:0] m, input int nb, input int k,
                                         input logic [31:0] poly);
    logic [63:0] g;
    g = {32'b0, poly} | (64'b1 << k);
    for (int i = nb - 1; i >= k; i--)
      if (m[i]) m = m ^ (g << (i - k));
    return m[31:0] & ((32'b1 << k) - 32'b1);
  endfunction

  task automatic model(input bit s, input logic [31:0] data, input bit inj, input logic [4:0] pos,
                       output logic [63:0] line, output logic [31:0] d, output bit err);
    int dw, k, fw;
    logic [31:0] poly;
    logic [63:0] frame;
    dw   = s ? 16 : 8;
    k    = s ? 8 : 3;
    poly = s ? 32'h07 : 32'h3;
    fw   = dw + k;
    data = data & ((32'b1 << dw) - 32'b1);
    frame = {32'b0, data} << k;
    frame = frame | {32'b0, rem_of(frame, fw, k, poly)};
    if (inj && int'(pos) < fw) frame = frame ^ (64'b1 << (fw - 1 - int'(pos)));
    line = frame;
    d    = 32'(frame >> k);
    err  = (rem_of(frame, fw, k, poly) != 0);
  endtask

  // Sends one frame in loopback; en_pct<0 alternates Enable 0/1 and pulses Start mid-frame.
  task automatic run_frame(input bit s, input logic [31:0] data, input bit inj, input logic [4:0] pos,
                           input int en_pct, input logic [63:0] exp_line, input logic [31:0] exp_data,
                           input bit exp_err, input string nm);
    int fw, idx, cyc;
    bit e;
    fw  = s ? 24 : 11;
    sel = s;
    if (s) begin din_b = data[15:0]; inj_b = inj; pos_b = pos; start_b = 1; en_b = 1; end
    else begin din_a = data[7:0]; inj_a = inj; pos_a = pos[3:0]; start_a = 1; en_a = 1; lb_a = 1; end
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    idx = 0; cyc = 0;
    while (idx < fw && cyc < 400) begin
      if (en_pct < 0) e = cyc[0];
      else e = ($urandom_range(99) < en_pct);
      if (en_pct < 0 && cyc == 11) begin start_a = 1; din_a = 8'hFF; end
      else start_a = 0;
      en_a = s ? 1'b0 : e;
      en_b = s ? e : 1'b0;
      @(negedge clk);
      n_tests++;
      if ({t_busy, t_txv, t_txo} !== {2'b11, exp_line[fw-1-idx]}) begin
        n_fail++;
        $display("FAIL %s line bit %0d: busy/valid/out=%b required %b", nm, idx,
                 {t_busy, t_txv, t_txo}, {2'b11, exp_line[fw-1-idx]});
      end
      @(posedge clk); #1;
      if (e) idx++;
      cyc++;
    end
    start_a = 0;
    n_tests++;
    if (idx < fw) begin
      n_fail++;
      $display("FAIL %s timeout: %0d bits sent, required %0d", nm, idx, fw);
    end
    if (en_pct < 0) begin
      n_tests++;
      if (cyc != 22) begin
        n_fail++;
        $display("FAIL %s frame length: %0d cycles, required 22", nm, cyc);
      end
    end
    en_a = ~s; en_b = s;
    @(negedge clk);
    n_tests++;
    if ({t_busy, t_rx_done, t_err} !== {1'b0, 1'b1, exp_err} || t_rx_data !== exp_data) begin
      n_fail++;
      $display("FAIL %s rx end: busy/done/err=%b data=%h required %b data=%h", nm,
               {t_busy, t_rx_done, t_err}, t_rx_data, {1'b0, 1'b1, exp_err}, exp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (t_rx_done !== 1'b0 || t_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done pulse: done/busy=%b%b required 00", nm, t_rx_done, t_busy);
    end
    @(posedge clk); #1;
    if (!s) begin last_err_a = exp_err; last_data_a = exp_data[7:0]; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    n_tests++;
    if ({busy_a, txo_a, txv_a, rx_done_a, err_a, rxdata_a, busy_b, txo_b, txv_b, rx_done_b, err_b, rxdata_b} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: a=%b b=%b required all 0",
               {busy_a, txo_a, txv_a, rx_done_a, err_a, rxdata_a},
               {busy_b, txo_b, txv_b, rx_done_b, err_b, rxdata_b});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_tests++;
    if ({busy_a, txv_a, rx_done_a, busy_b, txv_b, rx_done_b} !== '0) begin
      n_fail++;
      $display("FAIL after reset idle: %b required 000000",
               {busy_a, txv_a, rx_done_a, busy_b, txv_b, rx_done_b});
    end
    @(posedge clk); #1;
    last_err_a = 0; last_data_a = 0;
  endtask

  task automatic test_loopback_clean();
    run_frame(0, 32'hA5, 0, 5'd0, 100, 64'b101_0010_1101, 32'hA5, 1'b0, "clean_a5");
  endtask

  task automatic test_inject();
    run_frame(0, 32'hA5, 1, 5'd9, 100, 64'b101_0010_1111, 32'hA5, 1'b1, "inject_pos9");
    run_frame(0, 32'hA5, 1, 5'd0, 100, 64'b001_0010_1101, 32'h25, 1'b1, "inject_pos0");
  endtask

  task automatic test_rx_abort();
    logic [2:0] steps[$];
    logic [10:0] fr;
    logic       h_err;
    logic [7:0] h_data;
    h_err  = last_err_a;
    h_data = last_data_a;
    fr     = 11'b101_0010_1101;
    for (int i = 0; i < 5; i++) steps.push_back({1'b1, 1'b0, 1'($urandom_range(1))});
    steps.push_back({1'b1, 1'b1, 1'($urandom_range(1))});
    steps.push_back(3'b000);
    for (int i = 10; i >= 0; i--) steps.push_back({1'b1, 1'b0, fr[i]});
    sel = 0; lb_a = 0;
    foreach (steps[k]) begin
      rxv_m = steps[k][2]; abort_a = steps[k][1]; rxin_m = steps[k][0];
      @(negedge clk);
      n_tests++;
      if ({rx_done_a, err_a, rxdata_a} !== {1'b0, h_err, h_data}) begin
        n_fail++;
        $display("FAIL rx_abort hold step %0d: done/err/data=%b/%b/%h required 0/%b/%h",
                 k, rx_done_a, err_a, rxdata_a, h_err, h_data);
      end
      @(posedge clk); #1;
    end
    rxv_m = 0; abort_a = 0; rxin_m = 0;
    @(negedge clk);
    n_tests++;
    if ({rx_done_a, err_a, rxdata_a} !== {1'b1, 1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL rx_abort frame: done/err/data=%b/%b/%h required 1/0/a5",
               rx_done_a, err_a, rxdata_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (rx_done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_abort single pulse: done=%b required 0", rx_done_a);
    end
    @(posedge clk); #1;
    lb_a = 1;
    last_err_a = 0; last_data_a = 8'hA5;
  endtask

  task automatic test_enable_toggle();
    run_frame(0, 32'h00, 0, 5'd0, -1, 64'b0, 32'h00, 1'b0, "enable_toggle");
  endtask

  task automatic test_random_a();
    logic [63:0] ln; logic [31:0] dd; bit ee;
    logic [31:0] data; bit inj; logic [4:0] pos;
    for (int i = 0; i < 24; i++) begin
      data = $urandom_range(255);
      inj  = 1'($urandom_range(1));
      pos  = 5'($urandom_range(15));
      model(0, data, inj, pos, ln, dd, ee);
      run_frame(0, data, inj, pos, 60, ln, dd, ee, "random_a");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] l1, l2; logic [31:0] d1, d2; bit e1, e2;
    logic [31:0] x1, x2;
    x1 = $urandom_range(255);
    x2 = $urandom_range(255);
    model(0, x1, 0, 5'd0, l1, d1, e1);
    model(0, x2, 0, 5'd0, l2, d2, e2);
    sel = 0; lb_a = 1; en_a = 1; inj_a = 0; din_a = x1[7:0]; start_a = 1;
    @(posedge clk); #1;
    din_a = x2[7:0];
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 11; j++) begin
        @(negedge clk);
        n_tests++;
        if ({busy_a, txo_a} !== {1'b1, (f == 0 ? l1[10-j] : l2[10-j])}) begin
          n_fail++;
          $display("FAIL b2b frame %0d bit %0d: busy/out=%b required %b", f, j,
                   {busy_a, txo_a}, {1'b1, (f == 0 ? l1[10-j] : l2[10-j])});
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++;
      if ({busy_a, rx_done_a, err_a, rxdata_a} !== {1'b0, 1'b1, (f == 0 ? e1 : e2), (f == 0 ? d1[7:0] : d2[7:0])}) begin
        n_fail++;
        $display("FAIL b2b frame %0d end: busy/done/err=%b data=%h required 01%b data=%h", f,
                 {busy_a, rx_done_a, err_a}, rxdata_a, (f == 0 ? e1 : e2), (f == 0 ? d1[7:0] : d2[7:0]));
      end
      @(posedge clk); #1;
      start_a = 0;
    end
    last_err_a = e2; last_data_a = d2[7:0];
  endtask

  task automatic test_reset_midframe();
    sel = 0; lb_a = 1; en_a = 1; inj_a = 0; din_a = 8'h3C; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe busy before reset: %b required 1", busy_a);
    end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({busy_a, txo_a, txv_a, rx_done_a, err_a, rxdata_a} !== '0) begin
      n_fail++;
      $display("FAIL midframe reset outputs: %b required all 0",
               {busy_a, txo_a, txv_a, rx_done_a, err_a, rxdata_a});
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy_a, rx_done_a} !== 2'b00) begin
        n_fail++;
        $display("FAIL midframe after release cycle %0d: busy/done=%b required 00", i, {busy_a, rx_done_a});
      end
    end
    @(posedge clk); #1;
    last_err_a = 0; last_data_a = 0;
  endtask

  task automatic test_param_sweep();
    logic [63:0] ln; logic [31:0] dd; bit ee;
    logic [31:0] data;
    for (int i = 0; i < 64; i++) begin
      data = $urandom_range(65535);
      model(1, data, 0, 5'd0, ln, dd, ee);
      run_frame(1, data, 0, 5'd0, 80, ln, dd, ee, "sweep_clean");
    end
    for (int p = 0; p < 32; p++) begin
      data = $urandom_range(65535);
      model(1, data, 1, 5'(p), ln, dd, ee);
      run_frame(1, data, 1, 5'(p), 100, ln, dd, ee, "sweep_inject");
    end
    en_b = 0;
    sel = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; sel = 0; lb_a = 1;
    en_a = 0; start_a = 0; inj_a = 0; abort_a = 0; din_a = 0; pos_a = 0; rxin_m = 0; rxv_m = 0;
    en_b = 0; start_b = 0; inj_b = 0; abort_b = 0; din_b = 0; pos_b = 0;
    last_err_a = 0; last_data_a = 0;
    test_reset();
    test_loopback_clean();
    test_inject();
    test_rx_abort();
    test_enable_toggle();
    test_random_a();
    test_back_to_back();
    test_reset_midframe();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
